// File: rtl/max7219_frame_driver.sv
// max7219_frame_driver: serialises MM:SS:CC digits to a MAX7219 over SPI mode 0.
// Define MAX7219_DP_EN to light the separator dots on the sec_0X and min_0X digits.
module max7219_frame_driver #(
  parameter int         CLK_DIV   = 4,
  parameter int         CS_GAP    = 2,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] min_X0,
  input  logic [3:0] min_0X,
  input  logic [2:0] sec_X0,
  input  logic [3:0] sec_0X,
  input  logic [3:0] ces_X0,
  input  logic [3:0] ces_0X,
  output logic       mosi,
  output logic       cs,
  output logic       sclk,
  output logic       busy,
  output logic       frame_done
);
  localparam int DMAX = CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP;
  localparam int DW   = $clog2(DMAX + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;
  state_t        r_state, w_next;
  logic          r_init_done;
  logic [3:0]    r_idx;
  logic [4:0]    r_half;
  logic [DW-1:0] r_div;
  logic [2:0]    r_min_x0, r_sec_x0;
  logic [3:0]    r_min_0x, r_sec_0x, r_ces_x0, r_ces_0x;
  logic [3:0]    w_digit;
  logic [15:0]   w_word;
  logic          w_dp, w_start, w_div_end, w_gap_end, w_tx;
  assign w_div_end = r_div == DW'(CLK_DIV - 1);
  assign w_gap_end = r_div == DW'(CS_GAP - 1);
  assign w_start   = ena && (r_state == IDLE || r_state == DONE);
  assign w_tx      = r_state == LOAD || r_state == SHIFT;
  // Word index 0..4 are the init words, 5..10 the digit registers 1..6.
  always_comb begin
    w_dp = 1'b0;
`ifdef MAX7219_DP_EN
    w_dp = r_idx == 4'd7 || r_idx == 4'd9;
`else
    w_dp = 1'b0;
`endif
    w_digit = r_idx == 4'd5 ? r_ces_0x :
              r_idx == 4'd6 ? r_ces_x0 :
              r_idx == 4'd7 ? r_sec_0x :
              r_idx == 4'd8 ? {1'b0, r_sec_x0} :
              r_idx == 4'd9 ? r_min_0x : {1'b0, r_min_x0};
    w_word = r_idx == 4'd0 ? 16'h0C01 :
             r_idx == 4'd1 ? 16'h09FF :
             r_idx == 4'd2 ? {12'h0A0, INTENSITY} :
             r_idx == 4'd3 ? 16'h0B05 :
             r_idx == 4'd4 ? 16'h0F00 : {4'h0, r_idx - 4'd4, w_dp, 3'b000, w_digit};
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = ena ? LOAD : IDLE;
      LOAD:    w_next = SHIFT;
      SHIFT:   w_next = (w_div_end && &r_half) ? GAP : SHIFT;
      GAP:     w_next = w_gap_end ? (r_idx == 4'd10 ? DONE : LOAD) : GAP;
      DONE:    w_next = ena ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
    cs         = !w_tx;
    sclk       = r_state == SHIFT && r_half[0];
    mosi       = w_tx && w_word[~r_half[4:1]];
    busy       = w_tx || r_state == GAP;
    frame_done = r_state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_done <= 1'b0;
      r_idx       <= '0;
      r_half      <= '0;
      r_div       <= '0;
      r_min_x0    <= '0;
      r_min_0x    <= '0;
      r_sec_x0    <= '0;
      r_sec_0x    <= '0;
      r_ces_x0    <= '0;
      r_ces_0x    <= '0;
    end else begin
      if (w_start) begin
        r_min_x0 <= min_X0;
        r_min_0x <= min_0X;
        r_sec_x0 <= sec_X0;
        r_sec_0x <= sec_0X;
        r_ces_x0 <= ces_X0;
        r_ces_0x <= ces_0X;
        r_idx    <= (r_init_done || r_state == DONE) ? 4'd5 : 4'd0;
      end else if (r_state == GAP && w_gap_end && r_idx != 4'd10) begin
        r_idx <= r_idx + 4'd1;
      end
      r_div <= ((r_state == SHIFT && !w_div_end) || (r_state == GAP && !w_gap_end)) ? r_div + DW'(1) : '0;
      if (r_state == SHIFT && w_div_end) r_half <= r_half + 5'd1;
      if (r_state == DONE) r_init_done <= 1'b1;
    end
  end
endmodule
